// File: rtl/fpu_add_seq_ctrl.sv
// Sequential binary32 add/subtract: one operand pair per handshake, stepped through
// align, add, normalise and pack on a shared 25-bit mantissa path.
module fpu_add_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags
);

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StDone} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic        eff_sub_q, eff_sub_d;
  logic [7:0]  exp_q, exp_d;
  logic [7:0]  dist_q, dist_d;
  logic [24:0] ma_q, ma_d;
  logic [24:0] mb_q, mb_d;
  logic        neg_zero_q, neg_zero_d;
  logic        spec_q, spec_d;
  logic        spec_nan_q, spec_nan_d;
  logic        spec_inv_q, spec_inv_d;
  logic [31:0] res_q, res_d;
  logic [2:0]  flags_q, flags_d;

  // Operand decode for the accept cycle
  logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
  logic [7:0]  ea, eb, hi_e, lo_e;
  logic [24:0] ma_in, mb_in, hi_m, lo_m;

  always_comb begin
    sa    = in_a[31];
    sb    = in_b[31] ^ in_sub;
    ea    = in_a[30:23];
    eb    = in_b[30:23];
    a_nan = (ea == 8'hFF) && (in_a[22:0] != 23'd0);
    b_nan = (eb == 8'hFF) && (in_b[22:0] != 23'd0);
    a_inf = (ea == 8'hFF) && (in_a[22:0] == 23'd0);
    b_inf = (eb == 8'hFF) && (in_b[22:0] == 23'd0);
    // Exp=0 inputs are flushed to a zero mantissa
    ma_in = (ea == 8'd0) ? 25'd0 : {2'b01, in_a[22:0]};
    mb_in = (eb == 8'd0) ? 25'd0 : {2'b01, in_b[22:0]};
    swap  = (eb > ea) || ((eb == ea) && (mb_in > ma_in));
    hi_e  = swap ? eb : ea;
    lo_e  = swap ? ea : eb;
    hi_m  = swap ? mb_in : ma_in;
    lo_m  = swap ? ma_in : mb_in;
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    eff_sub_d  = eff_sub_q;
    exp_d      = exp_q;
    dist_d     = dist_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    neg_zero_d = neg_zero_q;
    spec_d     = spec_q;
    spec_nan_d = spec_nan_q;
    spec_inv_d = spec_inv_q;
    res_d      = res_q;
    flags_d    = flags_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          eff_sub_d  = (sa != sb);
          exp_d      = hi_e;
          dist_d     = hi_e - lo_e;
          ma_d       = hi_m;
          mb_d       = lo_m;
          neg_zero_d = sa && sb && (ma_in == 25'd0) && (mb_in == 25'd0);
          spec_d     = (ea == 8'hFF) || (eb == 8'hFF);
          spec_inv_d = a_inf && b_inf && (sa != sb);
          spec_nan_d = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
          if ((ea == 8'hFF) || (eb == 8'hFF)) begin
            sign_d = a_inf ? sa : sb;
          end else begin
            sign_d = swap ? sb : sa;
          end
          state_d = StAlign;
        end
      end
      StAlign: begin
        if (spec_q) begin
          res_d   = spec_nan_q ? 32'h7FC0_0000 : {sign_q, 8'hFF, 23'd0};
          flags_d = {spec_inv_q, 2'b00};
          state_d = StDone;
        end else if (dist_q == 8'd0) begin
          state_d = StAdd;
        end else if (dist_q >= 8'd25) begin
          mb_d    = 25'd0;
          state_d = StAdd;
        end else begin
          mb_d   = mb_q >> 1;
          dist_d = dist_q - 8'd1;
          if (dist_q == 8'd1) begin
            state_d = StAdd;
          end
        end
      end
      StAdd: begin
        // Swap at accept guarantees ma_q >= mb_q
        ma_d    = eff_sub_q ? (ma_q - mb_q) : (ma_q + mb_q);
        state_d = StNorm;
      end
      StNorm: begin
        if (ma_q == 25'd0) begin
          res_d   = {neg_zero_q, 31'd0};
          flags_d = 3'b000;
          state_d = StDone;
        end else if (ma_q[24]) begin
          if (exp_q == 8'd254) begin
            res_d   = {sign_q, 8'hFF, 23'd0};
            flags_d = 3'b010;
            state_d = StDone;
          end else begin
            ma_d  = ma_q >> 1;
            exp_d = exp_q + 8'd1;
          end
        end else if (!ma_q[23]) begin
          if (exp_q <= 8'd1) begin
            res_d   = {sign_q, 31'd0};
            flags_d = 3'b001;
            state_d = StDone;
          end else begin
            ma_d  = ma_q << 1;
            exp_d = exp_q - 8'd1;
          end
        end else begin
          res_d   = {sign_q, exp_q, ma_q[22:0]};
          flags_d = 3'b000;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      exp_q      <= 8'd0;
      dist_q     <= 8'd0;
      ma_q       <= 25'd0;
      mb_q       <= 25'd0;
      neg_zero_q <= 1'b0;
      spec_q     <= 1'b0;
      spec_nan_q <= 1'b0;
      spec_inv_q <= 1'b0;
      res_q      <= 32'd0;
      flags_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      eff_sub_q  <= eff_sub_d;
      exp_q      <= exp_d;
      dist_q     <= dist_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      neg_zero_q <= neg_zero_d;
      spec_q     <= spec_d;
      spec_nan_q <= spec_nan_d;
      spec_inv_q <= spec_inv_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_result = res_q;
  assign out_flags  = flags_q;

endmodule

// File: doc/fpu_add_seq_ctrl.md
# fpu_add_seq_ctrl

Multi-cycle sequencer for single-precision add/subtract in the floating-point unit. It accepts one operand pair under a valid/ready handshake, then steps a shared 25-bit mantissa register through four phases: align (one-bit right shift per cycle), add/subtract, normalise (one-bit shift per cycle), and pack. It replaces the wide combinational priority normaliser on the add path with a serial shifter and FSM, trading latency for area. It sits between the FPU issue logic and the FP register-file writeback.

## Interface
- No parameters. Format fixed at IEEE-754 binary32.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in IDLE.
- in_a  in  32  operand A.
- in_b  in  32  operand B.
- in_sub  in  1  1 = A−B, 0 = A+B.
- flush  in  1  synchronous abort; next state IDLE, result discarded.
- out_valid  out  1  result valid, high only in DONE.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  packed result.
- out_flags  out  3  {invalid, overflow, underflow}; valid with out_valid.

## Operation
- **States:** IDLE, ALIGN, ADD, NORM, DONE.
- **Accept** (IDLE, in_valid=1):
  - Register operands. Effective sign of B = b[31]^in_sub.
  - Exp=0 operands are flushed to ±0. Hidden bit is bit 23 of the 25-bit mantissa; bit 24 is carry.
  - Swap so A holds the larger magnitude: compare exponent, then mantissa. Result sign = sign of larger operand.
- **Special path** (either exp=255): go directly to DONE.
  - Any NaN, or inf−inf (effective) → 0x7FC00000. invalid=1 only for inf−inf.
  - Otherwise inf with its sign.
- **Zero operand:** the zero is just a mantissa of 0 and follows the normal path.
- **ALIGN:** d = expA−expB.
  - d=0: one cycle, no shift.
  - d≥25: mB←0 in one cycle.
  - Otherwise one right shift of mB per cycle and d−1, leaving when d reaches 0. Bits shifted out are discarded (truncation).
- **ADD:** one cycle.
  - m ← mA+mB if signs match, else mA−mB. Never negative because of the swap.
- **NORM:** one adjustment per cycle, checked in this order:
  - m=0 → result zero, go to DONE.
  - m[24]=1 → m>>1, exp+1. If exp becomes 255 → ±inf, overflow=1, go to DONE.
  - m[23]=0 → m<<1, exp−1. If exp would become 0 → ±0, underflow=1, go to DONE.
  - Otherwise normalised → go to DONE.
- **Pack:** {sign, exp, m[22:0]}.
  - Exact zero result is +0x00000000, except that both operands −0 (effective) gives 0x80000000.
- **DONE:** hold out_result, out_flags and out_valid until out_ready=1, then go to IDLE. No accept in the same cycle.
- **flush:** from any state → IDLE next edge; out_valid drops. flush beats a simultaneous handshake.

## Timing
- **Reset values:**
  - State IDLE: in_ready=1, out_valid=0, out_result=0, out_flags=0.
  - Datapath registers cleared.
  - Reset mid-operation drops the operation with no output.
- **in_ready** is combinational from state only; it never depends on in_valid.
- **Latency** L = edges from the accept edge to the first cycle with out_valid=1:
  - Normal path: L = A + 1 + N.
  - A = 1 if d∈{0} or d≥25, else d.
  - N = number of NORM shifts + 1. Exception: zero, overflow and underflow exits end NORM in the cycle they are detected.
  - Special path: L=1.
- **Outputs** are registered and stable while out_valid=1 and out_ready=0.
- **Throughput:** one op per L+1 cycles minimum (DONE→IDLE costs one cycle).

## Test plan
- 1.0+1.0: 0x3F800000+0x3F800000, sub=0 → 0x40000000, flags 0, L=4 (A=1, ADD, NORM shift, NORM check).
- 1.0 + −0.75: 0x3F800000+0xBF400000 → 0x3E800000, L=5. Then 1.0+0.5: 0x3F800000+0x3F000000 → 0x3FC00000, L=3.
- Cancellation and specials:
  - 0x3F800000−0x3F800000 → 0x00000000.
  - 0x7F800000−0x7F800000 → 0x7FC00000, invalid=1, L=1.
  - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, overflow=1.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid. Result and flags stay stable and in_ready stays 0. A new in_valid is ignored until one cycle after out_ready=1.
- Large exponent gap: 0x4B800000+0x3F800000 (d=24) gives A=24, result 0x4B800000 (truncated). With d=30, A=1 and A is returned unchanged.
- Abort and reset: flush asserted in the third ALIGN cycle, and separately rst_n pulsed low during NORM. Both give IDLE next edge and in_ready=1 with no out_valid pulse. A following op 2.0+2.0 → 0x40800000.
